// File: rtl/arith_pkg.sv
// Shared definitions for the small-area serial arithmetic datapath.
package arith_pkg;

  // FSM state encoding is shared with the serial adder.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Supported operand widths for the serial units.
  localparam int unsigned W_MIN = 2;
  localparam int unsigned W_MAX = 16;

  // Bit-position counter width: enough to count 0..w-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_sub_bit.sv
// Single-bit full subtractor: x - y - bin.
module full_sub_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bnext
);

  // Difference bit and borrow-out of one bit position.
  always_comb begin
    d     = x ^ y ^ bin;
    bnext = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/ser_sub.sv
// Bit-serial subtractor: computes a - b LSB-first through one full-subtractor
// cell, presenting both a parallel result and a serial bit stream.
module ser_sub
  import arith_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         done,
  output logic         busy,
  output logic         bit_out,
  output logic         bit_valid
);

  localparam int unsigned         CW   = cnt_width(W);
  localparam logic [CW-1:0]       LAST = CW'(W - 1);

  generate
    if (W < W_MIN || W > W_MAX) begin : g_bad_width
      $error("ser_sub: W out of supported range");
    end
  endgenerate

  state_t         state;
  logic [W-1:0]   ra;
  logic [W-1:0]   rb;
  logic           br;
  logic [CW-1:0]  count;
  logic           cell_d;
  logic           cell_bnext;

  full_sub_bit u_cell (
    .x     (ra[0]),
    .y     (rb[0]),
    .bin   (br),
    .d     (cell_d),
    .bnext (cell_bnext)
  );

  // Control FSM plus operand/result shift registers, all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ra        <= '0;
      rb        <= '0;
      br        <= 1'b0;
      count     <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bit_valid <= 1'b0;
          bit_out   <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            br    <= 1'b0;
            count <= '0;
            diff  <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          diff      <= {cell_d, diff[W-1:1]};
          ra        <= {1'b0, ra[W-1:1]};
          rb        <= {1'b0, rb[W-1:1]};
          br        <= cell_bnext;
          bit_out   <= cell_d;
          bit_valid <= 1'b1;
          if (count == LAST) begin
            // Counter is parked at zero on exit so it never wraps mid-operation.
            count <= '0;
            bout  <= cell_bnext;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_sub.sv
// Self-checking bench for ser_sub (W=4): table vectors, random operations
// against an arithmetic reference, and multi-cycle corner sequences.
module tb_ser_sub;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         bout;
  logic         done;
  logic         busy;
  logic         bit_out;
  logic         bit_valid;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ser_sub #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .diff      (diff),
    .bout      (bout),
    .done      (done),
    .busy      (busy),
    .bit_out   (bit_out),
    .bit_valid (bit_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] ediff;
    logic         ebout;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: unsigned difference modulo 2^W and borrow when a < b.
  function automatic logic [W-1:0] ref_diff(input int unsigned x, input int unsigned y);
    int m;
    m = (int'(x) - int'(y) + (1 << W)) % (1 << W);
    return m[W-1:0];
  endfunction

  function automatic logic ref_bout(input int unsigned x, input int unsigned y);
    return x < y;
  endfunction

  // One full operation starting from IDLE or DONE; a/b are scrambled during RUN.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ed, input logic eb, input string tag);
    a = ia; b = ib; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " accept done"}, done, 0);
    chk({tag, " accept busy"}, busy, 1);
    chk({tag, " accept bit_valid"}, bit_valid, 0);
    for (int i = 0; i < int'(W); i++) begin
      a = W'($urandom); b = W'($urandom);
      tick();
      chk($sformatf("%s bit_valid[%0d]", tag, i), bit_valid, 1);
      chk($sformatf("%s bit_out[%0d]", tag, i), bit_out, ed[i]);
      if (i < int'(W) - 1) begin
        chk($sformatf("%s done early[%0d]", tag, i), done, 0);
        chk($sformatf("%s busy[%0d]", tag, i), busy, 1);
      end
    end
    chk({tag, " diff"}, diff, ed);
    chk({tag, " bout"}, bout, eb);
    chk({tag, " done"}, done, 1);
    chk({tag, " busy end"}, busy, 0);
    tick();
    chk({tag, " hold bit_valid"}, bit_valid, 0);
    chk({tag, " hold done"}, done, 1);
    chk({tag, " hold diff"}, diff, ed);
    chk({tag, " hold bout"}, bout, eb);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " diff"}, diff, 0);
    chk({tag, " bout"}, bout, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " bit_out"}, bit_out, 0);
    chk({tag, " bit_valid"}, bit_valid, 0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [W-1:0] ra, rb;
    int unsigned  gap, seen;

    vecs[0] = '{4'd9,  4'd3,  4'd6,  1'b0};
    vecs[1] = '{4'd3,  4'd9,  4'd10, 1'b1};
    vecs[2] = '{4'd15, 4'd15, 4'd0,  1'b0};
    vecs[3] = '{4'd0,  4'd0,  4'd0,  1'b0};
    vecs[4] = '{4'd0,  4'd1,  4'd15, 1'b1};
    vecs[5] = '{4'd8,  4'd15, 4'd9,  1'b1};

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk("idle busy", busy, 0);

    foreach (vecs[i])
      run_op(vecs[i].va, vecs[i].vb, vecs[i].ediff, vecs[i].ebout, $sformatf("vec%0d", i));

    // Random operations with random dwell time in DONE.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom); rb = W'($urandom);
      run_op(ra, rb, ref_diff(ra, rb), ref_bout(ra, rb), $sformatf("rnd%0d", n));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < int'(gap); g++) begin
        tick();
        chk("dwell done", done, 1);
        chk("dwell diff", diff, ref_diff(ra, rb));
      end
    end

    // start held high throughout, operands churned during RUN, back-to-back.
    a = 4'd9; b = 4'd3; start = 1'b1;
    tick();
    chk("held accept1 done", done, 0);
    for (int i = 0; i < int'(W); i++) begin
      if (i < int'(W) - 1) begin a = W'($urandom); b = W'($urandom); end
      else begin a = 4'd7; b = 4'd12; end
      tick();
    end
    chk("held op1 done", done, 1);
    chk("held op1 diff", diff, 6);
    chk("held op1 bout", bout, 0);
    chk("held op1 bit_valid", bit_valid, 1);
    tick();
    chk("held accept2 done", done, 0);
    chk("held accept2 busy", busy, 1);
    for (int i = 0; i < int'(W); i++) begin
      a = W'($urandom); b = W'($urandom);
      tick();
    end
    chk("held op2 done", done, 1);
    chk("held op2 diff", diff, ref_diff(7, 12));
    chk("held op2 bout", bout, 1);
    start = 1'b0;
    tick();

    // Reset on the second RUN cycle abandons the operation.
    a = 4'd9; b = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("midreset");
    seen = 0;
    for (int i = 0; i < int'(W) + 2; i++) begin
      tick();
      if (done || busy || bit_valid) seen++;
    end
    chk("midreset no activity", seen, 0);
    run_op(4'd5, 4'd2, 4'd3, 1'b0, "after_reset");

    // Simultaneous reset and start: reset wins, FSM stays idle.
    a = 4'd1; b = 4'd2; start = 1'b1; reset = 1'b1;
    tick();
    chk_all_zero("rst_start");
    reset = 1'b0; start = 1'b0;
    tick();
    chk("rst_start idle busy", busy, 0);
    chk("rst_start idle bit_valid", bit_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
